// File: rtl/vga_pkg.sv
// Shared constants and state type for the rectangle-fill engine.
// The frame geometry here is what the top and the clipper are built for.
package vga_pkg;
   localparam int FB_W       = 320;
   localparam int FB_H       = 240;
   localparam int ADDR_WIDTH = 17;
   localparam int DATA_WIDTH = 24;
   localparam int CW         = 10;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      FILL,
      DONE
   } fill_state_t;
endpackage

// File: rtl/vga_rect_fill_if.sv
// Command, abort and frame-buffer write signals of the rectangle-fill engine.
// master is the command/arbiter side, slave is the engine.
interface vga_rect_fill_if;
   import vga_pkg::*;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [CW-1:0]         cmd_x0;
   logic [CW-1:0]         cmd_y0;
   logic [CW-1:0]         cmd_w;
   logic [CW-1:0]         cmd_h;
   logic [DATA_WIDTH-1:0] cmd_color;
   logic                  abort;
   logic                  fb_gnt;
   logic                  fb_wen;
   logic [ADDR_WIDTH-1:0] fb_waddr;
   logic [DATA_WIDTH-1:0] fb_wdata;
   logic                  busy;
   logic                  done;
   logic                  aborted;

   modport master (
      output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, abort, fb_gnt,
      input  cmd_ready, fb_wen, fb_waddr, fb_wdata, busy, done, aborted
   );

   modport slave (
      input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, abort, fb_gnt,
      output cmd_ready, fb_wen, fb_waddr, fb_wdata, busy, done, aborted
   );
endinterface

// File: rtl/vga_rect_fill_clip.sv
// Combinational clipper: exclusive end bounds saturated at the frame edge,
// plus an empty flag for rectangles that produce no pixels.
module rect_clip
   import vga_pkg::*;
(
   input  logic [CW-1:0] x0,
   input  logic [CW-1:0] y0,
   input  logic [CW-1:0] w,
   input  logic [CW-1:0] h,
   output logic [CW:0]   x_end,
   output logic [CW:0]   y_end,
   output logic          empty
);
   logic [CW:0] x_sum;
   logic [CW:0] y_sum;

   // 11 bits hold x0+w without wrapping, so saturation is exact
   assign x_sum = {1'b0, x0} + {1'b0, w};
   assign y_sum = {1'b0, y0} + {1'b0, h};

   assign x_end = (x_sum > 11'(FB_W)) ? 11'(FB_W) : x_sum;
   assign y_end = (y_sum > 11'(FB_H)) ? 11'(FB_H) : y_sum;

   assign empty = (w == '0) || (h == '0) ||
                  ({1'b0, x0} >= 11'(FB_W)) || ({1'b0, y0} >= 11'(FB_H));
endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: accepts one command, clips it to the frame and
// emits one frame-buffer write per granted cycle in raster order.
//
//   state | meaning
//   IDLE  | ready for a command
//   SETUP | clip and compute first address
//   FILL  | one write per granted cycle
//   DONE  | one-cycle completion pulse
module vga_rect_fill
   import vga_pkg::*;
(
   input  logic            clk,
   input  logic            n_rst,
   vga_rect_fill_if.slave  bus
);
   fill_state_t           state;
   fill_state_t           state_nxt;

   logic [CW-1:0]         x0_q;
   logic [CW-1:0]         y0_q;
   logic [CW-1:0]         w_q;
   logic [CW-1:0]         h_q;
   logic [DATA_WIDTH-1:0] color_q;
   logic [CW:0]           x_end_q;
   logic [CW:0]           y_end_q;
   logic [CW:0]           x_q;
   logic [CW:0]           y_q;
   logic [ADDR_WIDTH-1:0] row_base_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic                  aborted_q;

   logic [CW:0]           x_end_c;
   logic [CW:0]           y_end_c;
   logic                  empty_c;
   logic [ADDR_WIDTH-1:0] y0_ext;
   logic [ADDR_WIDTH-1:0] row_base_c;
   logic [ADDR_WIDTH-1:0] next_row_base;
   logic                  accept;
   logic                  wr;
   logic                  x_more;
   logic                  y_more;

   rect_clip u_clip (
      .x0    (x0_q),
      .y0    (y0_q),
      .w     (w_q),
      .h     (h_q),
      .x_end (x_end_c),
      .y_end (y_end_c),
      .empty (empty_c)
   );

   assign accept        = (state == IDLE) && bus.cmd_valid;
   assign wr            = (state == FILL) && bus.fb_gnt;
   assign x_more        = (x_q + 11'd1) < x_end_q;
   assign y_more        = (y_q + 11'd1) < y_end_q;
   // y0*320 as two shifts so no multiplier is needed
   assign y0_ext        = ADDR_WIDTH'(y0_q);
   assign row_base_c    = (y0_ext << 8) + (y0_ext << 6);
   assign next_row_base = row_base_q + ADDR_WIDTH'(FB_W);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   state_nxt = empty_c ? DONE : FILL;
         FILL: begin
            if (bus.abort)                     state_nxt = DONE;
            else if (wr && !x_more && !y_more) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready = (state == IDLE);
      bus.busy      = (state != IDLE);
      bus.done      = (state == DONE);
      bus.fb_wen    = wr;
   end

   assign bus.fb_waddr = waddr_q;
   assign bus.fb_wdata = color_q;
   assign bus.aborted  = aborted_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         x0_q       <= '0;
         y0_q       <= '0;
         w_q        <= '0;
         h_q        <= '0;
         color_q    <= '0;
         x_end_q    <= '0;
         y_end_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         row_base_q <= '0;
         waddr_q    <= '0;
         aborted_q  <= 1'b0;
      end else begin
         if (accept) begin
            x0_q      <= bus.cmd_x0;
            y0_q      <= bus.cmd_y0;
            w_q       <= bus.cmd_w;
            h_q       <= bus.cmd_h;
            color_q   <= bus.cmd_color;
            aborted_q <= 1'b0;
         end
         // empty commands keep the old address so fb_waddr never leaves the frame
         if (state == SETUP && !empty_c) begin
            x_end_q    <= x_end_c;
            y_end_q    <= y_end_c;
            x_q        <= {1'b0, x0_q};
            y_q        <= {1'b0, y0_q};
            row_base_q <= row_base_c;
            waddr_q    <= row_base_c + ADDR_WIDTH'(x0_q);
         end
         if (wr) begin
            if (x_more) begin
               x_q     <= x_q + 11'd1;
               waddr_q <= waddr_q + 1'b1;
            end else if (y_more) begin
               x_q        <= {1'b0, x0_q};
               y_q        <= y_q + 11'd1;
               row_base_q <= next_row_base;
               waddr_q    <= next_row_base + ADDR_WIDTH'(x0_q);
            end
         end
         if (state == FILL && bus.abort) aborted_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: directed scenarios plus random commands, checked
// against a pixel-list model built from the clipped rectangle.
module tb_vga_rect_fill;
   import vga_pkg::*;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   vga_rect_fill_if bus ();

   vga_rect_fill dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   int n_asserts = 0;
   int n_fail    = 0;
   bit last_ab   = 1'b0;
   int gnt_pat[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_garbage();
      bus.cmd_x0    = 10'($urandom);
      bus.cmd_y0    = 10'($urandom);
      bus.cmd_w     = 10'($urandom);
      bus.cmd_h     = 10'($urandom);
      bus.cmd_color = 24'($urandom);
   endtask

   // Runs one command from IDLE until the engine is ready again.
   // abort_at = k aborts on the k-th granted write (0 = no abort).
   task automatic run_fill(input int x0, input int y0, input int w, input int h,
                           input logic [23:0] col, input int abort_at, input bit rand_gnt);
      int exp_q[$];
      int xe, ye, idx, done_c;
      bit ab_exp, finished, g, a, in_fill;
      xe = (x0 + w < FB_W) ? x0 + w : FB_W;
      ye = (y0 + h < FB_H) ? y0 + h : FB_H;
      for (int yy = y0; yy < ye; yy++)
         for (int xx = x0; xx < xe; xx++)
            exp_q.push_back(yy * FB_W + xx);

      @(negedge clk);
      bus.cmd_x0    = 10'(x0);
      bus.cmd_y0    = 10'(y0);
      bus.cmd_w     = 10'(w);
      bus.cmd_h     = 10'(h);
      bus.cmd_color = col;
      bus.cmd_valid = 1'b1;
      bus.fb_gnt    = 1'b1;
      bus.abort     = 1'($urandom);
      #1;
      chk("ready_idle", bus.cmd_ready, 1);
      chk("wen_idle", bus.fb_wen, 0);
      chk("aborted_sticky", bus.aborted, last_ab);

      @(negedge clk);
      bus.cmd_valid = 1'($urandom);
      drive_garbage();
      bus.fb_gnt = 1'b1;
      bus.abort  = 1'($urandom);
      #1;
      chk("busy_setup", bus.busy, 1);
      chk("ready_setup", bus.cmd_ready, 0);
      chk("wen_setup", bus.fb_wen, 0);
      chk("aborted_clear", bus.aborted, 0);

      idx      = 0;
      ab_exp   = 1'b0;
      finished = 1'b0;
      done_c   = (exp_q.size() == 0) ? 2 : -1;
      for (int c = 2; c < 6000; c++) begin
         @(negedge clk);
         in_fill = (done_c < 0);
         g = 1'b0;
         a = 1'b0;
         if (in_fill) begin
            if (gnt_pat.size() > 0) g = 1'(gnt_pat.pop_front());
            else                    g = rand_gnt ? 1'($urandom) : 1'b1;
            if (abort_at > 0 && idx == abort_at - 1 && g) a = 1'b1;
            bus.fb_gnt    = g;
            bus.abort     = a;
            bus.cmd_valid = 1'($urandom);
            drive_garbage();
         end else begin
            bus.fb_gnt    = 1'($urandom);
            bus.abort     = 1'($urandom);
            bus.cmd_valid = 1'b0;
         end
         #1;
         if (in_fill) begin
            chk("wen_fill", bus.fb_wen, g);
            chk("waddr", bus.fb_waddr, exp_q[idx]);
            chk("wdata", bus.fb_wdata, col);
            chk("done_early", bus.done, 0);
            if (g) idx++;
            if (a) ab_exp = 1'b1;
            if (a || idx == exp_q.size()) done_c = c + 1;
         end else if (c == done_c) begin
            chk("done_pulse", bus.done, 1);
            chk("wen_done", bus.fb_wen, 0);
            chk("busy_done", bus.busy, 1);
         end else begin
            chk("ready_after", bus.cmd_ready, 1);
            chk("done_single", bus.done, 0);
            chk("busy_after", bus.busy, 0);
            chk("aborted_flag", bus.aborted, ab_exp);
            finished = 1'b1;
            break;
         end
      end
      chk("timeout", finished, 1);
      bus.fb_gnt = 1'b0;
      bus.abort  = 1'b0;
      last_ab    = ab_exp;
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_x0    = '0;
      bus.cmd_y0    = '0;
      bus.cmd_w     = '0;
      bus.cmd_h     = '0;
      bus.cmd_color = '0;
      bus.abort     = 1'b0;
      bus.fb_gnt    = 1'b1;
      #1;
      chk("rst_ready", bus.cmd_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_aborted", bus.aborted, 0);
      chk("rst_wen", bus.fb_wen, 0);
      chk("rst_waddr", bus.fb_waddr, 0);
      chk("rst_wdata", bus.fb_wdata, 0);
      repeat (2) @(negedge clk);
      n_rst      = 1'b1;
      bus.fb_gnt = 1'b0;

      run_fill(0, 0, 2, 2, 24'hFF0000, 0, 1'b0);
      run_fill(318, 238, 4, 4, 24'h00FF00, 0, 1'b0);
      run_fill(10, 10, 0, 5, 24'h0000FF, 0, 1'b0);
      run_fill(320, 0, 1, 1, 24'h0000FF, 0, 1'b0);
      gnt_pat = '{1, 0, 0, 1, 1};
      run_fill(5, 1, 3, 1, 24'h123456, 0, 1'b0);
      gnt_pat.delete();
      run_fill(0, 3, 10, 1, 24'hABCDEF, 3, 1'b0);
      run_fill(7, 7, 2, 1, 24'h010203, 0, 1'b0);
      run_fill(300, 5, 1023, 2, 24'h808080, 0, 1'b1);

      @(negedge clk);
      bus.cmd_x0    = 10'd0;
      bus.cmd_y0    = 10'd0;
      bus.cmd_w     = 10'd20;
      bus.cmd_h     = 10'd5;
      bus.cmd_color = 24'h5A5A5A;
      bus.cmd_valid = 1'b1;
      bus.fb_gnt    = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("wen_before_rst", bus.fb_wen, 1);
      chk("busy_before_rst", bus.busy, 1);
      #1 n_rst = 1'b0;
      #1;
      chk("midrst_wen", bus.fb_wen, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_ready", bus.cmd_ready, 1);
      chk("midrst_done", bus.done, 0);
      chk("midrst_waddr", bus.fb_waddr, 0);
      chk("midrst_wdata", bus.fb_wdata, 0);
      repeat (2) @(negedge clk);
      n_rst      = 1'b1;
      bus.fb_gnt = 1'b0;
      last_ab    = 1'b0;
      run_fill(1, 1, 3, 2, 24'hC0FFEE, 0, 1'b0);

      for (int i = 0; i < 25; i++) begin
         int rx, ry, rw, rh, ra;
         rx = $urandom_range(0, 340);
         ry = $urandom_range(0, 250);
         rw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 12);
         rh = $urandom_range(0, 5);
         ra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
         run_fill(rx, ry, rw, rh, 24'($urandom), ra, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Hardware rectangle-fill engine that sits directly upstream of the frame buffer write port, in parallel with the bus write path. It accepts one fill command: origin, size and 24-bit colour. It clips the rectangle to the 320x240 frame, then emits one frame-buffer write per granted cycle in raster order. The top level arbitrates its write strobe against the bus subordinate using `fb_gnt`.

## Interface
Parameters:
- `FB_W`, 320, frame width in pixels
- `FB_H`, 240, frame height in pixels
- `ADDR_WIDTH`, 17, frame-buffer address width (word address = y*FB_W + x)
- `DATA_WIDTH`, 24, pixel width, {R[23:16], G[15:8], B[7:0]}

Ports:
- `clk` in 1: system clock (50 MHz domain); the block has one clock.
- `n_rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine idle, can accept a command.
- `cmd_x0`, `cmd_y0` in 10 each: rectangle origin.
- `cmd_w`, `cmd_h` in 10 each: width and height in pixels.
- `cmd_color` in DATA_WIDTH: fill colour.
- `abort` in 1: stop the current fill.
- `fb_gnt` in 1: write port granted this cycle.
- `fb_wen` out 1: write strobe to frame buffer.
- `fb_waddr` out ADDR_WIDTH: write address.
- `fb_wdata` out DATA_WIDTH: write data.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle completion pulse.
- `aborted` out 1: sticky; last command ended by abort; cleared on next accept.

## Operation
States are IDLE, SETUP, FILL and DONE.

**IDLE**
- `cmd_ready`=1.
- On `cmd_valid`, register x0, y0, w, h and colour, clear `aborted`, go to SETUP.

**SETUP** (one cycle)
- Clip with 11-bit arithmetic:
  - x_end = min(x0+w, FB_W)
  - y_end = min(y0+h, FB_H)
- The command is empty if w==0, h==0, x0>=FB_W or y0>=FB_H. An empty command goes to DONE with no writes.
- Otherwise:
  - row_base = y0*320, computed as (y0<<8)+(y0<<6), with no multiplier.
  - waddr = row_base + x0, x = x0, y = y0.
  - Go to FILL.

**FILL**
- `fb_wen` = `fb_gnt`. This is the only combinational input-to-output path.
- `fb_waddr` and `fb_wdata` are registered and held stable while `fb_gnt`=0.
- On a granted cycle:
  - If x+1 < x_end: x++ and waddr++.
  - Else if y+1 < y_end: x = x0, y++, row_base += FB_W, waddr = new row_base + x0.
  - Else: go to DONE.
- If `abort`=1 in FILL: a write granted in the same cycle still completes. Then set `aborted`=1 and go to DONE.
- `abort` is ignored in IDLE, SETUP and DONE.

**DONE** (one cycle)
- `done`=1, then go to IDLE.

Further rules:
- `cmd_*` inputs are ignored while `cmd_ready`=0.
- `cmd_w` and `cmd_h` are unsigned. Clipping saturates the end bound at the frame size; there is no wrap-around.
- Addresses never exceed FB_W*FB_H-1 = 76799.

## Timing
- The accept edge starts cycle 0. SETUP is cycle 1. The first write is possible in cycle 2.
- N pixels with `fb_gnt` held high: writes in cycles 2..N+1, `done` in cycle N+2, `cmd_ready`=1 in cycle N+3.
- Each `fb_gnt`=0 cycle in FILL adds exactly one cycle.
- Empty command: `done` in cycle 2, zero writes.
- Throughput is one pixel per granted cycle, including across row transitions (no bubble).
- Reset values:
  - state IDLE
  - `cmd_ready`=1
  - `busy`=0, `done`=0, `aborted`=0
  - `fb_wen`=0
  - `fb_waddr`=0, `fb_wdata`=0
- Reset asserted mid-FILL:
  - Outputs take their reset values immediately, asynchronously.
  - No `done` pulse is produced.
  - The partial fill is not undone.

## Structure
Shared package `vga_pkg`:
- FB_W, FB_H
- ADDR_WIDTH, DATA_WIDTH
- enum `fill_state_t` {IDLE, SETUP, FILL, DONE}

Sub-module `rect_clip`:
- Combinational x0/y0/w/h → x_end, y_end, empty.
- Used in SETUP; unit-testable on its own.

## Test plan
- **Basic fill:** cmd (0,0,2,2,0xFF0000), `fb_gnt`=1 → writes to 0, 1, 320, 321 in cycles 2–5, all with data 0xFF0000; `done` in cycle 6.
- **Clip:** cmd (318,238,4,4,0x00FF00) → exactly 4 writes, to 76478, 76479, 76798, 76799; no address above 76799.
- **Empty:** cmd (10,10,0,5) and cmd (320,0,1,1) → zero `fb_wen`; `done` in cycle 2 after accept.
- **Grant stalls:** 1x3 fill at (5,1) with `fb_gnt` pattern 1,0,0,1,1 → addresses 325, 326, 327; waddr held at 326 across the stall; `done` 2 cycles later than the unstalled case.
- **Abort:** `abort` pulsed with `fb_gnt`=1 on the 3rd write of a 10x1 fill → exactly 3 writes; `done` next cycle; `aborted`=1; `aborted` cleared on the next accept.
- **Reset mid-fill:** `n_rst` low during FILL → `fb_wen`=0 and `busy`=0 asynchronously; after release, `cmd_ready`=1 and a new command runs normally.
